bin_to_bcd_scan: RTL and testbench
==================================

Name: bin_to_bcd_scan

Overview:
- Upstream stage of the seven-segment decoder.
- Takes a binary value and converts it to packed BCD with a sequential double-dabble engine.
- Holds the result and time-multiplexes the digits onto one shared 4-bit BCD bus with active-low anode enables.
- bcd_out feeds the decoder's BCD input directly; an drives the board anodes.

Parameters:
- BIN_W, 16, width of the binary input.
- DIGITS, 5, number of BCD digits converted and scanned.
- SCAN_DIV, 50000, clock cycles each digit stays enabled (1 kHz per digit at 50 MHz); must be >= 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- bin_in  input  BIN_W  binary value to convert; sampled only on an accepted load.
- load  input  1  conversion request; accepted only when busy=0.
- busy  output  1  high while a conversion is in progress.
- bcd_out  output  4  BCD nibble of the currently selected digit, to decoder.
- an  output  DIGITS  anode enables, active low, one-hot-zero.
- bcd_all  output  4*DIGITS  committed BCD result; digit 0 (units) is bits [3:0].

Behaviour:
- Single clock domain; reset is synchronous and active-high on rst.
- Reset values:
  - FSM = IDLE, busy=0.
  - Committed register bcd_all=0.
  - Scan index=0, prescaler=0.
  - an = all ones except bit 0 = 0.
  - bcd_out=0.
- Conversion FSM states:
  - IDLE: on load=1, capture bin_in into the shift register, clear the 4*DIGITS scratch, set bit counter=BIN_W, go to SHIFT, busy=1.
  - SHIFT: each cycle, every scratch nibble >= 5 gets +3, then {scratch,shift} shifts left by 1; counter decrements. When counter reaches 1 on this step, go to DONE.
  - DONE: copy scratch to bcd_all; go to IDLE; busy=0 from the next edge.
- Latency: load accepted at edge k.
  - busy is high for edges k+1 .. k+BIN_W+1.
  - bcd_all holds the new value after edge k+BIN_W+1; busy=0 in that same cycle.
  - Total BIN_W+1 busy cycles.
- Load handling:
  - load while busy=1 is ignored; it is not queued.
  - load held high re-triggers on the first IDLE cycle.
- Tear-free display: bcd_all and the scan outputs show the previous result for the whole conversion; they change atomically on DONE.
- Overflow: carries out of the top nibble are discarded, so the result is bin_in mod 10^DIGITS. Defaults (16/5) never overflow.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 free-running, independent of the FSM.
  - On terminal count it returns to 0 and the index advances; it wraps DIGITS-1 -> 0.
  - an = ~(1 << index); bcd_out = bcd_all nibble[index].
  - Both are driven from registers and change on the same edge, so no mixed digit/anode cycle.
- Edge cases:
  - SCAN_DIV=1: index advances every cycle.
  - DIGITS=1: index stays 0.
- rst mid-conversion aborts it: scratch is discarded, bcd_all=0, busy=0 on the next edge.

Optional Feature:
- Macro: BIN_TO_BCD_SCAN_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - Any digit above the most significant nonzero digit is blanked: its an bit stays 1 for its scan slot, and bcd_out = 0 during that slot.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The blank mask is computed from bcd_all and registered alongside it.
- Undefined: all DIGITS digits always lit, leading zeros shown.

Decomposition:
- Package display_pkg:
  - DIGIT_W=4, ANODE_ON=1'b0.
  - FSM state localparams IDLE/SHIFT/DONE.
  - function add3_if_ge5 for a 4-bit nibble.
- Sub-module digit_scanner:
  - Contains prescaler, index, anode and nibble mux, and blank mask.
  - Takes bcd_all; reused by other display blocks.
- The conversion FSM stays in the top module.

Test Plan (sim SCAN_DIV=4, defaults otherwise):
- Reset: assert rst 2 cycles -> busy=0, bcd_all=0, an=5'b11110, bcd_out=0.
- Convert: load=1 with bin_in=16'd1234 for 1 cycle -> busy high exactly 17 cycles; then bcd_all=20'h01234 and busy=0.
- Max value: bin_in=16'hFFFF -> bcd_all=20'h65535. Then bin_in=0 -> bcd_all=20'h00000.
- Load during busy: load 16'd1234, then at cycle 5 load 16'd9999 -> result 01234; second load ignored; busy not extended.
- Scan: with bcd_all=20'h65535:
  - an sequence is 11110, 11101, 11011, 10111, 01111, each held 4 cycles, wrapping after 20 cycles.
  - bcd_out is 5, 3, 5, 5, 6 in lock-step.
  - bcd_out/an unchanged during a new conversion until DONE.
- LZ blank (macro defined):
  - value 42 -> an bits 4..2 never 0; digits 0/1 show 2/4.
  - value 0 -> only an[0] ever asserted, bcd_out=0.
  - Rst at cycle 8 of a conversion -> busy=0 and bcd_all=0 next cycle.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the binary-to-BCD / digit-scan display path.
//   DIGIT_W      : width of one BCD digit
//   ANODE_ON     : anode level that lights a digit (boards use active-low)
//   conv_state_e : states of the double-dabble conversion FSM
//   add3_if_ge5  : double-dabble nibble correction step
// Optional feature macro used by this slice: BIN_TO_BCD_SCAN_LZ_BLANK_EN
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int   DIGIT_W  = 4;
  localparam logic ANODE_ON = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Nibbles of 5..9 get +3 so that the following left shift carries into the
  // next decimal digit exactly when the doubled value reaches 10.
  function automatic logic [DIGIT_W-1:0] add3_if_ge5(input logic [DIGIT_W-1:0] nib);
    logic [DIGIT_W-1:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/digit_scanner.sv
// -----------------------------------------------------------------------------
// digit_scanner
// Time-multiplexes a packed BCD value onto one 4-bit digit bus with one-hot
// anode enables. A free-running prescaler sets how long each digit is lit.
// Ports:
//   clk_i      : clock, all state on rising edge
//   rst_i      : synchronous active-high reset
//   bcd_all_i  : packed BCD value, digit 0 (units) in [3:0]
//   bcd_out_o  : nibble of the currently selected digit (registered)
//   an_o       : anode enables, ANODE_ON level selects (registered)
// Macro BIN_TO_BCD_SCAN_LZ_BLANK_EN: blank digits above the most significant
// nonzero digit (digit 0 is never blanked).
// -----------------------------------------------------------------------------
module digit_scanner
  import display_pkg::*;
#(
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [4*DIGITS-1:0]    bcd_all_i,
  output logic [DIGIT_W-1:0]     bcd_out_o,
  output logic [DIGITS-1:0]      an_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DIGITS-1:0]  blank_d;
  logic [DIGITS-1:0]  an_d, an_q;
  logic [DIGIT_W-1:0] nib_d, bcd_out_q;
`ifdef BIN_TO_BCD_SCAN_LZ_BLANK_EN
  logic               seen_d;
`endif

  // Prescaler terminal count advances the digit index, wrapping at the top digit.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Leading-zero blank mask: a digit is blank while no nonzero digit sits at or above it.
  always_comb begin
    blank_d = '0;
`ifdef BIN_TO_BCD_SCAN_LZ_BLANK_EN
    seen_d  = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (bcd_all_i[d*DIGIT_W +: DIGIT_W] != 4'd0) begin
        seen_d = 1'b1;
      end else begin
        seen_d = seen_d;
      end
      blank_d[d] = ~seen_d;
    end
`endif
  end

  // Anode and nibble for the upcoming index; a blanked slot lights nothing and drives 0.
  always_comb begin
    an_d  = {DIGITS{~ANODE_ON}};
    nib_d = bcd_all_i[DIGIT_W*idx_d +: DIGIT_W];
    if (blank_d[idx_d]) begin
      nib_d = 4'd0;
    end else begin
      an_d[idx_d] = ANODE_ON;
    end
  end

  // Scan state and outputs; anode and nibble always update on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      idx_q     <= '0;
      an_q      <= {DIGITS{~ANODE_ON}};
      an_q[0]   <= ANODE_ON;
      bcd_out_q <= 4'd0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      bcd_out_q <= nib_d;
    end
  end

  assign an_o      = an_q;
  assign bcd_out_o = bcd_out_q;

endmodule

// File: rtl/bin_to_bcd_scan.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_scan
// Converts a binary value to packed BCD with a sequential double-dabble engine
// (one bit per cycle), commits the result atomically, and scans the committed
// digits onto a shared BCD bus with active-low anodes.
// Ports:
//   clk     : clock, all state on rising edge
//   rst     : synchronous active-high reset (aborts a running conversion)
//   bin_in  : binary value, sampled when a load is accepted
//   load    : conversion request, accepted only while busy is low
//   busy    : high while a conversion is in progress
//   bcd_out : nibble of the currently scanned digit
//   an      : anode enables, active low, one-hot-zero
//   bcd_all : committed BCD result, digit 0 in [3:0]
// Macro BIN_TO_BCD_SCAN_LZ_BLANK_EN enables leading-zero blanking in the scanner.
// -----------------------------------------------------------------------------
module bin_to_bcd_scan
  import display_pkg::*;
#(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIN_W-1:0]     bin_in,
  input  logic                 load,
  output logic                 busy,
  output logic [3:0]           bcd_out,
  output logic [DIGITS-1:0]    an,
  output logic [4*DIGITS-1:0]  bcd_all
);

  localparam int SW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  conv_state_e   state_q;
  logic [BIN_W-1:0] shift_q;
  logic [SW-1:0]    scratch_q;
  logic [SW-1:0]    scratch_adj_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [SW-1:0]    bcd_all_q;

  // Per-nibble +3 correction applied before every shift.
  always_comb begin
    scratch_adj_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      scratch_adj_d[d*DIGIT_W +: DIGIT_W] = add3_if_ge5(scratch_q[d*DIGIT_W +: DIGIT_W]);
    end
  end

  // Conversion FSM; the committed result only changes in DONE so the display never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_all_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            cnt_q     <= CNT_LOAD;
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        SHIFT: begin
          // Top scratch bit falls off: the result wraps modulo 10^DIGITS.
          {scratch_q, shift_q} <= {scratch_adj_d[SW-2:0], shift_q, 1'b0};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end
        DONE: begin
          bcd_all_q <= scratch_q;
          state_q   <= IDLE;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  digit_scanner #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk_i     (clk),
    .rst_i     (rst),
    .bcd_all_i (bcd_all_q),
    .bcd_out_o (bcd_out),
    .an_o      (an)
  );

  assign busy    = busy_q;
  assign bcd_all = bcd_all_q;

endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_scan
// Directed self-checking bench for bin_to_bcd_scan with SCAN_DIV=4.
// Define BIN_TO_BCD_SCAN_LZ_BLANK_EN to also exercise leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bin_in;
  logic        load;
  logic        busy;
  logic [3:0]  bcd_out;
  logic [4:0]  an;
  logic [19:0] bcd_all;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] an_seq   [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
  logic [3:0] d65535   [5] = '{4'd5, 4'd3, 4'd5, 4'd5, 4'd6};

  always #5 clk = ~clk;

  bin_to_bcd_scan #(
    .BIN_W    (16),
    .DIGITS   (5),
    .SCAN_DIV (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .load    (load),
    .busy    (busy),
    .bcd_out (bcd_out),
    .an      (an),
    .bcd_all (bcd_all)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one cycle, count busy cycles, check result.
  task automatic run_conv(input logic [15:0] val, input logic [19:0] exp_bcd, input string tag);
    int n;
    bin_in = val;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      tick();
    end
    check({tag, " busy cycles"}, 32'(n), 32'd17);
    check({tag, " bcd_all"}, 32'(bcd_all), 32'(exp_bcd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   idx;
    logic found;
    logic [4:0] prev;
    logic s0, s1;

    rst = 1'b1; load = 1'b0; bin_in = 16'd0;
    tick(); tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset bcd_all", 32'(bcd_all), 32'd0);
    check("reset an", 32'(an), 32'b11110);
    check("reset bcd_out", 32'(bcd_out), 32'd0);
    rst = 1'b0;

    run_conv(16'd1234, 20'h01234, "conv 1234");
    check("busy low after 1234", 32'(busy), 32'd0);
    run_conv(16'hFFFF, 20'h65535, "conv FFFF");

    // Scan sequence with 65535 committed
    prev  = an;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (an == 5'b11110 && prev != 5'b11110) begin
        found = 1'b1;
        break;
      end
      prev = an;
    end
    check("scan sync", 32'(found), 32'd1);
    if (found) begin
      for (int j = 0; j < 20; j++) begin
        check("scan an", 32'(an), 32'(an_seq[j/4]));
        check("scan bcd_out", 32'(bcd_out), 32'(d65535[j/4]));
        tick();
      end
      check("scan wrap an", 32'(an), 32'b11110);
      check("scan wrap bcd_out", 32'(bcd_out), 32'd5);
    end

    // Tear-free: display keeps 65535 throughout the conversion of 0
    bin_in = 16'd0;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      check("hold bcd_all", 32'(bcd_all), 32'h65535);
      idx = 0;
      for (int b = 0; b < 5; b++) begin
        if (an[b] == 1'b0) idx = b;
      end
      check("hold bcd_out", 32'(bcd_out), 32'(d65535[idx]));
      tick();
    end
    check("conv 0 busy cycles", 32'(n), 32'd17);
    check("conv 0 bcd_all", 32'(bcd_all), 32'h00000);

    // Load during busy is ignored and does not extend busy
    bin_in = 16'd1234;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      if (n == 5) begin
        bin_in = 16'd9999;
        load   = 1'b1;
      end else begin
        load   = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    check("ignored load busy cycles", 32'(n), 32'd17);
    check("ignored load bcd_all", 32'(bcd_all), 32'h01234);

    // Held load re-triggers on the first idle cycle
    bin_in = 16'd42;
    load   = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      tick();
    end
    check("held load busy cycles", 32'(n), 32'd17);
    check("held load bcd_all", 32'(bcd_all), 32'h00042);
    tick();
    check("held load retrigger", 32'(busy), 32'd1);
    load = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check("retrigger bcd_all", 32'(bcd_all), 32'h00042);

    // Reset in the middle of a conversion
    bin_in = 16'd1234;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    repeat (7) tick();
    check("pre-abort busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("abort busy", 32'(busy), 32'd0);
    check("abort bcd_all", 32'(bcd_all), 32'd0);
    check("abort an", 32'(an), 32'b11110);
    check("abort bcd_out", 32'(bcd_out), 32'd0);
    rst = 1'b0;
    tick();
    check("abort stays idle", 32'(busy), 32'd0);

`ifdef BIN_TO_BCD_SCAN_LZ_BLANK_EN
    run_conv(16'd42, 20'h00042, "lz 42");
    tick();
    s0 = 1'b0;
    s1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check("lz42 upper anodes off", 32'(an[4:2]), 32'b111);
      if (an == 5'b11110) begin
        s0 = 1'b1;
        check("lz42 digit0", 32'(bcd_out), 32'd2);
      end else if (an == 5'b11101) begin
        s1 = 1'b1;
        check("lz42 digit1", 32'(bcd_out), 32'd4);
      end else begin
        check("lz42 blank bcd_out", 32'(bcd_out), 32'd0);
      end
      tick();
    end
    check("lz42 both digits lit", 32'({s1, s0}), 32'b11);

    run_conv(16'd0, 20'h00000, "lz 0");
    tick();
    for (int i = 0; i < 40; i++) begin
      check("lz0 only digit0", 32'((an == 5'b11110) || (an == 5'b11111)), 32'd1);
      check("lz0 bcd_out", 32'(bcd_out), 32'd0);
      tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
